// File: rtl/gcore_isa_pkg.sv
// gcore_isa_pkg
//   Shared ISA definitions for the fetch/branch path: the default address and
//   instruction widths, the control-flow opcodes, and small helpers that slice
//   the opcode and target fields out of an instruction word.
//   Instruction layout: op = instr[15:12], tgt = instr[7:0].
package gcore_isa_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_BZ   = 4'hD;
  localparam logic [OP_W-1:0] OP_CALL = 4'hE;
  localparam logic [OP_W-1:0] OP_RET  = 4'hF;

  function automatic logic [OP_W-1:0] op_of(input logic [IW_DEF-1:0] i);
    return i[IW_DEF-1 -: OP_W];
  endfunction

  function automatic logic [AW_DEF-1:0] tgt_of(input logic [IW_DEF-1:0] i);
    return i[AW_DEF-1:0];
  endfunction

endpackage

// File: rtl/fetch_branch_unit_return_stack.sv
// return_stack
//   Hardware return-address stack for CALL/RET. Only the stack pointer is
//   reset; entry storage is left uninitialised since an entry is never read
//   before it has been pushed.
// Ports
//   clk, rst   clock, synchronous active-high reset (clears sp)
//   push       write push_data at sp, sp+1 (caller guarantees !full)
//   pop        sp-1 (caller guarantees !empty); top is valid before the pop
//   push_data  return address to store
//   top        most recently pushed entry (meaningless when empty)
//   full/empty sp == DEPTH / sp == 0
module return_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  // One extra bit so sp can represent DEPTH itself (full).
  localparam int SPW = $clog2(DEPTH) + 1;

  logic [AW-1:0]  mem [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] sp_m1;

  assign sp_m1 = sp_q - SPW'(1);
  assign top   = mem[sp_m1[SPW-2:0]];
  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + SPW'(1);
    else if (pop) sp_d = sp_m1;
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[sp_q[SPW-2:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit
//   Consumer end of the PC interface. Tracks the address of the instruction
//   now on the synchronous ROM output, decodes control-flow opcodes and
//   redirects the PC. A taken redirect squashes exactly one wrong-path fetch
//   (the ROM word for pc_q+1, already in flight).
// Ports
//   clk, rst     clock, synchronous active-high reset
//   addr         current PC value (also the ROM address)
//   imem_rdata   ROM data for the previous cycle's addr
//   zero         datapath zero flag, used by BZ in its decode cycle
//   jump         load jumpaddr into the PC at the next edge (combinational)
//   jumpaddr     redirect target, 0 when jump is low
//   instr        instruction to datapath (= imem_rdata)
//   instr_valid  instr is architecturally valid this cycle
//   rs_ovf       sticky: CALL with the return stack full
//   rs_unf       sticky: RET with the return stack empty
module fetch_branch_unit
  import gcore_isa_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int IW       = IW_DEF,
  parameter int RS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          zero,
  output logic          jump,
  output logic [AW-1:0] jumpaddr,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic          rs_ovf,
  output logic          rs_unf
);

  logic [AW-1:0]   pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [OP_W-1:0] op;
  logic [AW-1:0]   tgt;
  logic            dec_en;
  logic            is_jmp, is_bz, is_call, is_ret;
  logic            take;
  logic            rs_push, rs_pop, rs_full, rs_empty;
  logic [AW-1:0]   rs_top;
  logic [AW-1:0]   ret_addr;

  assign op  = op_of(imem_rdata);
  assign tgt = AW'(tgt_of(imem_rdata));

  // Decode only a valid word, and never while reset is held so nothing
  // leaks onto jump or the stack during reset.
  assign dec_en  = valid_q & ~rst;
  assign is_jmp  = dec_en & (op == OP_JMP);
  assign is_bz   = dec_en & (op == OP_BZ);
  assign is_call = dec_en & (op == OP_CALL);
  assign is_ret  = dec_en & (op == OP_RET);

  // CALL with a full stack still jumps; RET on an empty stack falls through.
  assign take    = is_jmp | (is_bz & zero) | is_call | (is_ret & ~rs_empty);
  assign rs_push = is_call & ~rs_full;
  assign rs_pop  = is_ret & ~rs_empty;

  // Wraps modulo 2^AW, so a CALL at the top address returns to 0.
  assign ret_addr = pc_q + AW'(1);

  always_comb begin
    jumpaddr = '0;
    if (take) jumpaddr = is_ret ? rs_top : tgt;
  end

  always_comb begin
    pc_d    = addr;
    valid_d = ~take;
    ovf_d   = ovf_q | (is_call & rs_full);
    unf_d   = unf_q | (is_ret & rs_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  return_stack #(
    .AW    (AW),
    .DEPTH (RS_DEPTH)
  ) u_rs (
    .clk       (clk),
    .rst       (rst),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (ret_addr),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  assign jump        = take;
  assign instr       = imem_rdata;
  assign instr_valid = valid_q;
  assign rs_ovf      = ovf_q;
  assign rs_unf      = unf_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr;
  logic [15:0] imem_rdata;
  logic        zero = 1'b0;
  logic        jump;
  logic [7:0]  jumpaddr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        rs_ovf;
  logic        rs_unf;

  logic [15:0] rom [256];
  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // Environment: PC register and synchronous ROM.
  always_ff @(posedge clk) begin
    if (rst)       addr <= 8'h00;
    else if (jump) addr <= jumpaddr;
    else           addr <= addr + 8'h01;
    imem_rdata <= rom[addr];
  end

  fetch_branch_unit #(.AW(8), .IW(16), .RS_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .imem_rdata  (imem_rdata),
    .zero        (zero),
    .jump        (jump),
    .jumpaddr    (jumpaddr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .rs_ovf      (rs_ovf),
    .rs_unf      (rs_unf)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Leaves the bench at the start of the first cycle with rst low (addr=0).
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Compares {instr_valid, jump, jumpaddr}.
  task automatic chk_ctl(input string nm, input logic [9:0] exp);
    cmps++;
    if ({instr_valid, jump, jumpaddr} !== exp) begin
      errs++;
      $display("FAIL %s: {valid,jump,jumpaddr} got %b_%b_%h want %b_%b_%h", nm,
               instr_valid, jump, jumpaddr, exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic test_reset();
    clear_rom();
    rst = 1'b1;
    step();
    cmps++;
    if ({jump, instr_valid} !== 2'b00) begin
      errs++; $display("FAIL reset_hold: jump/valid got %b%b want 00", jump, instr_valid);
    end
    do_reset();
    cmps++;
    if ({instr_valid, jump, jumpaddr, rs_ovf, rs_unf, addr} !== {2'b00, 8'h00, 2'b00, 8'h00}) begin
      errs++; $display("FAIL reset_r0: v=%b j=%b ja=%h ovf=%b unf=%b addr=%h want all 0",
                       instr_valid, jump, jumpaddr, rs_ovf, rs_unf, addr);
    end
    step();
    cmps++;
    if ({instr_valid, jump, addr, instr} !== {2'b10, 8'h01, 16'h0000}) begin
      errs++; $display("FAIL reset_r1: v=%b j=%b addr=%h instr=%h want 1 0 01 0000",
                       instr_valid, jump, addr, instr);
    end
    step();
    cmps++;
    if ({instr_valid, jump, addr} !== {2'b10, 8'h02}) begin
      errs++; $display("FAIL reset_r2: v=%b j=%b addr=%h want 1 0 02", instr_valid, jump, addr);
    end
  endtask

  task automatic test_jmp();
    clear_rom();
    rom[8'h02] = 16'hC040;
    rom[8'h40] = 16'h1234;
    do_reset();
    repeat (3) step();
    chk_ctl("jmp_decode", {1'b1, 1'b1, 8'h40});
    step();
    chk_ctl("jmp_bubble", {1'b0, 1'b0, 8'h00});
    step();
    cmps++;
    if ({instr_valid, instr} !== {1'b1, 16'h1234}) begin
      errs++; $display("FAIL jmp_target: v=%b instr=%h want 1 1234", instr_valid, instr);
    end
  endtask

  task automatic test_bz();
    clear_rom();
    rom[8'h05] = 16'hD020;
    rom[8'h06] = 16'h0006;
    rom[8'h20] = 16'h2020;
    zero = 1'b0;
    do_reset();
    repeat (6) step();
    chk_ctl("bz_nt_decode", {1'b1, 1'b0, 8'h00});
    step();
    cmps++;
    if ({instr_valid, instr} !== {1'b1, 16'h0006}) begin
      errs++; $display("FAIL bz_nt_next: v=%b instr=%h want 1 0006", instr_valid, instr);
    end
    zero = 1'b1;
    do_reset();
    repeat (6) step();
    chk_ctl("bz_t_decode", {1'b1, 1'b1, 8'h20});
    step();
    chk_ctl("bz_t_bubble", {1'b0, 1'b0, 8'h00});
    step();
    cmps++;
    if ({instr_valid, instr} !== {1'b1, 16'h2020}) begin
      errs++; $display("FAIL bz_t_target: v=%b instr=%h want 1 2020", instr_valid, instr);
    end
    zero = 1'b0;
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[8'h10] = 16'hE080;
    rom[8'h80] = 16'hF000;
    rom[8'h11] = 16'h0011;
    do_reset();
    repeat (17) step();
    chk_ctl("call_decode", {1'b1, 1'b1, 8'h80});
    step();
    chk_ctl("call_bubble", {1'b0, 1'b0, 8'h00});
    step();
    chk_ctl("ret_decode", {1'b1, 1'b1, 8'h11});
    step();
    chk_ctl("ret_bubble", {1'b0, 1'b0, 8'h00});
    step();
    cmps++;
    if ({instr_valid, instr, rs_ovf, rs_unf} !== {1'b1, 16'h0011, 2'b00}) begin
      errs++; $display("FAIL ret_target: v=%b instr=%h ovf=%b unf=%b want 1 0011 0 0",
                       instr_valid, instr, rs_ovf, rs_unf);
    end
  endtask

  task automatic test_overflow();
    clear_rom();
    rom[8'h00] = 16'hE010;
    rom[8'h10] = 16'hE020;
    rom[8'h20] = 16'hE030;
    rom[8'h30] = 16'hE040;
    rom[8'h40] = 16'hE050;
    rom[8'h50] = 16'hF000;
    do_reset();
    repeat (9) step();
    chk_ctl("ovf_5th_call", {1'b1, 1'b1, 8'h50});
    cmps++;
    if (rs_ovf !== 1'b0) begin
      errs++; $display("FAIL ovf_before: rs_ovf got %b want 0", rs_ovf);
    end
    step();
    cmps++;
    if (rs_ovf !== 1'b1) begin
      errs++; $display("FAIL ovf_set: rs_ovf got %b want 1", rs_ovf);
    end
    step();
    // 5th push was dropped, so RET returns past the 4th CALL (at 0x30).
    chk_ctl("ovf_ret_top", {1'b1, 1'b1, 8'h31});
    step();
    step();
    cmps++;
    if ({instr_valid, rs_ovf, rs_unf} !== 3'b110) begin
      errs++; $display("FAIL ovf_sticky: v=%b ovf=%b unf=%b want 1 1 0", instr_valid, rs_ovf, rs_unf);
    end
  endtask

  task automatic test_underflow();
    clear_rom();
    rom[8'h00] = 16'hF000;
    rom[8'h01] = 16'h0101;
    do_reset();
    step();
    chk_ctl("unf_decode", {1'b1, 1'b0, 8'h00});
    step();
    cmps++;
    if ({instr_valid, instr, rs_unf, addr} !== {1'b1, 16'h0101, 1'b1, 8'h02}) begin
      errs++; $display("FAIL unf_next: v=%b instr=%h unf=%b addr=%h want 1 0101 1 02",
                       instr_valid, instr, rs_unf, addr);
    end
    step();
    cmps++;
    if (rs_unf !== 1'b1) begin
      errs++; $display("FAIL unf_sticky: rs_unf got %b want 1", rs_unf);
    end
  endtask

  task automatic test_call_wrap();
    clear_rom();
    rom[8'h00] = 16'hC0FF;
    rom[8'hFF] = 16'hE040;
    rom[8'h40] = 16'hF000;
    do_reset();
    step();
    chk_ctl("wrap_jmp", {1'b1, 1'b1, 8'hFF});
    step();
    step();
    chk_ctl("wrap_call", {1'b1, 1'b1, 8'h40});
    step();
    step();
    chk_ctl("wrap_ret", {1'b1, 1'b1, 8'h00});
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[8'h00] = 16'hF000;
    rom[8'h02] = 16'hC040;
    do_reset();
    repeat (3) step();
    chk_ctl("mid_pre_decode", {1'b1, 1'b1, 8'h40});
    rst = 1'b1;
    #1;
    chk_ctl("mid_rst_forced", {1'b1, 1'b0, 8'h00});
    step();
    cmps++;
    if ({instr_valid, jump, addr, rs_ovf, rs_unf} !== {2'b00, 8'h00, 2'b00}) begin
      errs++; $display("FAIL mid_after: v=%b j=%b addr=%h ovf=%b unf=%b want 0 0 00 0 0",
                       instr_valid, jump, addr, rs_ovf, rs_unf);
    end
    rst = 1'b0;
    step();
    cmps++;
    if ({instr_valid, instr, addr} !== {1'b1, 16'hF000, 8'h01}) begin
      errs++; $display("FAIL mid_restart: v=%b instr=%h addr=%h want 1 F000 01",
                       instr_valid, instr, addr);
    end
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_bz();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_call_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
